// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: horizontal and vertical porch/sync state machines that
// produce sync, blanking, pixel coordinates and line/frame markers for the pixel pipeline.
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       run,
  output logic       busy,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  typedef enum logic {TOP_IDLE, TOP_RUN} top_state_e;
  typedef enum logic [1:0] {AX_ACTIVE, AX_FP, AX_SYNC, AX_BP} axis_state_e;

  localparam logic [9:0] H_ACTIVE_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST     = 10'(H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST   = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BP_LAST     = 10'(H_BP - 1);
  localparam logic [9:0] V_ACTIVE_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST     = 10'(V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST   = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BP_LAST     = 10'(V_BP - 1);

  function automatic axis_state_e axis_next(input axis_state_e s);
    case (s)
      AX_ACTIVE: return AX_FP;
      AX_FP:     return AX_SYNC;
      AX_SYNC:   return AX_BP;
      default:   return AX_ACTIVE;
    endcase
  endfunction

  top_state_e  top_q, top_d;
  axis_state_e h_q, h_d, v_q, v_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

  logic [9:0] h_last_cnt, v_last_cnt;
  logic       h_wrap, v_wrap, end_of_line, end_of_frame;

  always_comb begin
    case (h_q)
      AX_ACTIVE: h_last_cnt = H_ACTIVE_LAST;
      AX_FP:     h_last_cnt = H_FP_LAST;
      AX_SYNC:   h_last_cnt = H_SYNC_LAST;
      default:   h_last_cnt = H_BP_LAST;
    endcase
    case (v_q)
      AX_ACTIVE: v_last_cnt = V_ACTIVE_LAST;
      AX_FP:     v_last_cnt = V_FP_LAST;
      AX_SYNC:   v_last_cnt = V_SYNC_LAST;
      default:   v_last_cnt = V_BP_LAST;
    endcase
  end

  assign h_wrap       = (h_cnt_q == h_last_cnt);
  assign v_wrap       = (v_cnt_q == v_last_cnt);
  assign end_of_line  = (h_q == AX_BP) && h_wrap;
  assign end_of_frame = end_of_line && (v_q == AX_BP) && v_wrap;

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    top_d   = top_q;
    h_d     = h_q;
    v_d     = v_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en) begin
      case (top_q)
        TOP_IDLE: begin
          // Counters already sit at (0,0), so the first RUN cycle is pixel (0,0).
          if (run) top_d = TOP_RUN;
        end
        TOP_RUN: begin
          if (h_wrap) begin
            h_d     = axis_next(h_q);
            h_cnt_d = '0;
          end else begin
            h_cnt_d = h_cnt_q + 10'd1;
          end
          if (end_of_line) begin
            if (v_wrap) begin
              v_d     = axis_next(v_q);
              v_cnt_d = '0;
            end else begin
              v_cnt_d = v_cnt_q + 10'd1;
            end
          end
          // The natural wrap already returns both axes to ACTIVE/0 when stopping.
          if (end_of_frame && !run) top_d = TOP_IDLE;
        end
        default: top_d = TOP_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q   <= TOP_IDLE;
      h_q     <= AX_ACTIVE;
      v_q     <= AX_ACTIVE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      top_q   <= top_d;
      h_q     <= h_d;
      v_q     <= v_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic running, h_active, v_active;

  assign running  = (top_q == TOP_RUN);
  assign h_active = running && (h_q == AX_ACTIVE);
  assign v_active = running && (v_q == AX_ACTIVE);

  assign busy        = running;
  assign hsync       = (running && (h_q == AX_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (running && (v_q == AX_SYNC)) ? SYNC_POL : ~SYNC_POL;
  assign video_on    = h_active && v_active;
  assign x           = h_active ? h_cnt_q : '0;
  assign y           = v_active ? v_cnt_q : '0;
  assign line_start  = h_active && (h_cnt_q == '0);
  assign frame_start = line_start && v_active && (v_cnt_q == '0);

endmodule
